// File: rtl/uart_apb_poller_pkg.sv
// Shared constants and types for the CoreUARTapb polling master.
package uart_apb_poller_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ERR_W      = 3;
    localparam int unsigned RX_W       = 11;
    localparam int unsigned POLL_CNT_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_TXDATA = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_RXDATA = 5'h04;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'h10;

    localparam int unsigned ST_TXRDY    = 0;
    localparam int unsigned ST_RXRDY    = 1;
    localparam int unsigned ST_PARITY   = 2;
    localparam int unsigned ST_OVERFLOW = 3;
    localparam int unsigned ST_FRAMING  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ST_SETUP,
        ST_ACCESS,
        RX_SETUP,
        RX_ACCESS,
        TX_SETUP,
        TX_ACCESS,
        WAIT
    } state_e;

    // err is {framing, overflow, parity}, taken from the preceding status read
    typedef struct packed {
        logic [ERR_W-1:0]  err;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through RX FIFO with a registered head entry.
module uart_rx_fifo
    import uart_apb_poller_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rx_entry_t push_data,
    input  logic      pop,
    output rx_entry_t head,
    output logic      valid,
    output logic      full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rx_entry_t        r_mem [DEPTH];
    rx_entry_t        r_head;
    rx_entry_t        w_head_n;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_n;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_n;
    logic             r_valid;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign w_push = push && !full;
    assign w_pop  = pop && r_valid;
    assign head   = r_head;
    assign valid  = r_valid;

    // Next head: a push into the slot that becomes the head bypasses the array
    always_comb begin
        w_rd_ptr_n = r_rd_ptr + PTR_W'(w_pop);
        w_count_n  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_head_n   = r_mem[w_rd_ptr_n];
        if (w_push && (w_rd_ptr_n == r_wr_ptr)) begin
            w_head_n = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_valid  <= (w_count_n != '0);
            if (w_count_n != '0) begin
                r_head <= w_head_n;
            end
        end
    end

endmodule

// File: rtl/uart_apb_poller.sv
// APB master that polls CoreUARTapb status, drains RX bytes into a FIFO
// and writes TX stream bytes whenever the UART reports TXRDY.
module uart_apb_poller
    import uart_apb_poller_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned RX_DEPTH      = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic [DATA_W-1:0] rx_data,
    output logic [ERR_W-1:0]  rx_err,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              apb_err
);

    localparam logic [POLL_CNT_W-1:0] POLL_RELOAD = POLL_CNT_W'(POLL_INTERVAL - 1);

    state_e                r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic                  r_tx_ready;
    logic                  r_apb_err;
    logic                  r_prio_tx;
    logic [ERR_W-1:0]      r_status_err;
    logic [POLL_CNT_W-1:0] r_wait_cnt;

    logic      w_rx_ok;
    logic      w_tx_ok;
    logic      w_sel_rx;
    logic      w_push;
    logic      w_fifo_full;
    rx_entry_t w_push_data;
    rx_entry_t w_head;

    assign PSEL     = r_psel;
    assign PENABLE  = r_penable;
    assign PWRITE   = r_pwrite;
    assign PADDR    = r_paddr;
    assign PWDATA   = r_pwdata;
    assign tx_ready = r_tx_ready;
    assign apb_err  = r_apb_err;
    assign rx_data  = w_head.data;
    assign rx_err   = w_head.err;

    // Poll decision; fullness is the registered count, so a same-cycle pop never helps
    assign w_rx_ok  = PRDATA[ST_RXRDY] && !w_fifo_full;
    assign w_tx_ok  = PRDATA[ST_TXRDY] && tx_valid;
    assign w_sel_rx = w_rx_ok && (!w_tx_ok || !r_prio_tx);

    assign w_push           = (r_state == RX_ACCESS) && PREADY && !PSLVERR;
    assign w_push_data.err  = r_status_err;
    assign w_push_data.data = PRDATA;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (PCLK),
        .rst       (PRESET),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (rx_ready),
        .head      (w_head),
        .valid     (rx_valid),
        .full      (w_fifo_full)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_tx_ready   <= 1'b0;
            r_apb_err    <= 1'b0;
            r_prio_tx    <= 1'b0;
            r_status_err <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_tx_ready <= 1'b0;
            case (r_state)
                IDLE, WAIT: begin
                    if ((r_state == IDLE) || (r_wait_cnt == '0)) begin
                        r_state   <= ST_SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= ADDR_STATUS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - POLL_CNT_W'(1);
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                RX_SETUP: begin
                    r_state   <= RX_ACCESS;
                    r_penable <= 1'b1;
                end
                TX_SETUP: begin
                    r_state   <= TX_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS, RX_ACCESS, TX_ACCESS: begin
                    if (PREADY) begin
                        r_penable <= 1'b0;
                        if (PSLVERR) begin
                            r_apb_err  <= 1'b1;
                            r_state    <= WAIT;
                            r_psel     <= 1'b0;
                            r_pwrite   <= 1'b0;
                            r_wait_cnt <= POLL_RELOAD;
                        end else if (r_state != ST_ACCESS) begin
                            // Data moved; poll again straight away
                            r_tx_ready <= (r_state == TX_ACCESS);
                            r_state    <= ST_SETUP;
                            r_pwrite   <= 1'b0;
                            r_paddr    <= ADDR_STATUS;
                        end else begin
                            r_status_err <= PRDATA[ST_FRAMING:ST_PARITY];
                            if (w_sel_rx) begin
                                r_state   <= RX_SETUP;
                                r_paddr   <= ADDR_RXDATA;
                                r_pwrite  <= 1'b0;
                                r_prio_tx <= 1'b1;
                            end else if (w_tx_ok) begin
                                r_state   <= TX_SETUP;
                                r_paddr   <= ADDR_TXDATA;
                                r_pwrite  <= 1'b1;
                                r_pwdata  <= tx_data;
                                r_prio_tx <= 1'b0;
                            end else begin
                                r_state    <= WAIT;
                                r_psel     <= 1'b0;
                                r_wait_cnt <= POLL_RELOAD;
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_poller.sv
// Directed bench: behavioural CoreUARTapb slave, RX/TX scoreboards, immediate assertions.
module tb_uart_apb_poller;
    import uart_apb_poller_pkg::*;

    logic              PCLK;
    logic              PRESET;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] rx_data;
    logic [ERR_W-1:0]  rx_err;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              apb_err;

    uart_apb_poller #(
        .POLL_INTERVAL (16),
        .RX_DEPTH      (4)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .rx_data  (rx_data),
        .rx_err   (rx_err),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .apb_err  (apb_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    rx_entry_t   uart_q [$];
    rx_entry_t   sb_q [$];
    logic [7:0]  tx_exp_q [$];
    int          stat_q [$];
    int          kind_q [$];

    logic        txrdy = 1'b0;
    int          tx_wait = 0;
    logic        tx_err = 1'b0;
    int          rx_wait = 0;
    int          tx_left = 0;
    logic [7:0]  tx_byte = 8'h00;
    logic [2:0]  last_flags = 3'b000;
    int          acc_cyc = 0;
    int          n_status = 0;
    int          n_rx = 0;
    int          n_tx_ok = 0;
    int          n_err = 0;
    int          n_tx_ready = 0;
    int          err_len = 0;
    int          err_cyc = 0;
    int          ok_cyc = 0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle=%0d limit=20000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic int cur(input int which);
        case (which)
            0:       return n_rx;
            1:       return n_tx_ok;
            default: return kind_q.size();
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int target, input int budget);
        int n = 0;
        while ((cur(which) < target) && (n < budget)) begin
            tick();
            n++;
        end
        chk(tag, 32'(cur(which) >= target), 32'd1);
    endtask

    task automatic push_uart(input logic [2:0] flags, input logic [7:0] data);
        rx_entry_t e;
        e.err  = flags;
        e.data = data;
        uart_q.push_back(e);
    endtask

    // UART slave model: status reflects the head byte, RX reads pop it
    always @(negedge PCLK) begin : slave
        logic [4:0] st;
        logic       is_tx;
        logic       is_rx;
        int         wreq;
        rx_entry_t  e;
        st = 5'b00000;
        st[ST_TXRDY] = txrdy;
        if (uart_q.size() > 0) begin
            st[ST_RXRDY]    = 1'b1;
            st[ST_PARITY]   = uart_q[0].err[0];
            st[ST_OVERFLOW] = uart_q[0].err[1];
            st[ST_FRAMING]  = uart_q[0].err[2];
        end
        if (PADDR == ADDR_STATUS) PRDATA = {3'b000, st};
        else if (uart_q.size() > 0) PRDATA = uart_q[0].data;
        else PRDATA = 8'h00;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        if (PSEL && PENABLE) begin
            is_tx = PWRITE && (PADDR == ADDR_TXDATA);
            is_rx = !PWRITE && (PADDR == ADDR_RXDATA);
            wreq  = is_tx ? tx_wait : (is_rx ? rx_wait : 0);
            if (acc_cyc < wreq) begin
                PREADY = 1'b0;
                acc_cyc++;
            end else begin
                PSLVERR = is_tx && tx_err;
                if (!PRESET) begin
                    if (PSLVERR) begin
                        n_err++;
                        err_len = acc_cyc + 1;
                        err_cyc = cyc;
                        tx_err  = 1'b0;
                        tx_wait = 0;
                    end else if (!PWRITE && (PADDR == ADDR_STATUS)) begin
                        n_status++;
                        last_flags = st[ST_FRAMING:ST_PARITY];
                        stat_q.push_back(cyc);
                    end else if (is_rx) begin
                        n_rx++;
                        e.err  = last_flags;
                        e.data = PRDATA;
                        sb_q.push_back(e);
                        if (uart_q.size() > 0) void'(uart_q.pop_front());
                        kind_q.push_back(0);
                    end else if (is_tx) begin
                        n_tx_ok++;
                        ok_cyc = cyc;
                        kind_q.push_back(1);
                        chk("tx_write_expected", 32'(tx_exp_q.size() != 0), 32'd1);
                        if (tx_exp_q.size() != 0) chk("tx_pwdata", 32'(PWDATA), 32'(tx_exp_q.pop_front()));
                    end else begin
                        chk("access_addr", {26'd0, PWRITE, PADDR}, {27'd0, ADDR_STATUS});
                    end
                end
                acc_cyc = 0;
            end
        end else begin
            acc_cyc = 0;
        end
    end

    // TX source and RX consumer scoreboard
    always @(negedge PCLK) begin : streams
        rx_entry_t exp_e;
        if (tx_ready) begin
            n_tx_ready++;
            if (tx_left > 0) tx_left--;
        end
        tx_valid = (tx_left > 0);
        tx_data  = tx_byte;
        if (!PRESET && rx_valid && rx_ready) begin
            chk("rx_pop_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_e = sb_q.pop_front();
                chk("rx_entry", {21'd0, rx_err, rx_data}, {21'd0, exp_e});
            end
        end
    end

    initial begin
        int base;
        int k0;
        int s0;
        int found;
        PRESET   = 1'b1;
        rx_ready = 1'b0;
        PRDATA   = 8'h00;
        PREADY   = 1'b1;
        PSLVERR  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", 32'(PWDATA), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_apb_err", 32'(apb_err), 32'd0);

        // Idle polling: status only, 2 + 16 cycle period
        PRESET = 1'b0;
        repeat (80) tick();
        chk("idle_rx_reads", 32'(n_rx), 32'd0);
        chk("idle_tx_writes", 32'(n_tx_ok), 32'd0);
        chk("idle_poll_count", 32'(n_status >= 3), 32'd1);
        if (stat_q.size() >= 2) chk("poll_period", 32'(stat_q[$] - stat_q[$-1]), 32'd18);
        chk("idle_rx_valid", 32'(rx_valid), 32'd0);

        // Single clean byte, held until consumed
        push_uart(3'b000, 8'hA5);
        wait_for("rx_a5_read", 0, 1, 100);
        repeat (10) tick();
        chk("a5_valid_held", 32'(rx_valid), 32'd1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_err", 32'(rx_err), 32'd0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        chk("a5_popped_valid", 32'(rx_valid), 32'd0);

        // Byte carrying framing + parity flags
        rx_ready = 1'b1;
        push_uart(3'b101, 8'h3C);
        wait_for("rx_3c_read", 0, 2, 100);
        repeat (5) tick();
        chk("rx_3c_consumed", 32'(sb_q.size()), 32'd0);

        // FIFO full: exactly RX_DEPTH reads, then one more per pop
        rx_ready = 1'b0;
        base = n_rx;
        for (int i = 0; i < 6; i++) push_uart(3'b000, 8'(8'h10 + i));
        repeat (200) tick();
        chk("full_rx_reads", 32'(n_rx - base), 32'd4);
        chk("full_uart_left", 32'(uart_q.size()), 32'd2);
        s0 = n_status;
        repeat (40) tick();
        chk("full_still_polling", 32'(n_status - s0 >= 2), 32'd1);
        chk("full_no_extra_read", 32'(n_rx - base), 32'd4);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (60) tick();
        chk("full_one_more_read", 32'(n_rx - base), 32'd5);
        rx_ready = 1'b1;
        repeat (80) tick();
        chk("full_drained_reads", 32'(n_rx - base), 32'd6);
        chk("full_drained_sb", 32'(sb_q.size()), 32'd0);

        // RX and TX both ready: round-robin
        k0 = kind_q.size();
        push_uart(3'b000, 8'hC1);
        push_uart(3'b000, 8'hC2);
        tx_byte = 8'h55;
        tx_exp_q.push_back(8'h55);
        tx_exp_q.push_back(8'h55);
        txrdy   = 1'b1;
        tx_left = 2;
        wait_for("rr_four_accesses", 2, k0 + 4, 300);
        if (kind_q.size() >= k0 + 4) begin
            chk("rr_alt_0", 32'(kind_q[k0] != kind_q[k0+1]), 32'd1);
            chk("rr_alt_1", 32'(kind_q[k0+1] != kind_q[k0+2]), 32'd1);
            chk("rr_alt_2", 32'(kind_q[k0+2] != kind_q[k0+3]), 32'd1);
            chk("rr_tx_count", 32'(kind_q[k0] + kind_q[k0+1] + kind_q[k0+2] + kind_q[k0+3]), 32'd2);
        end
        repeat (20) tick();
        chk("rr_tx_exp_empty", 32'(tx_exp_q.size()), 32'd0);
        chk("rr_tx_ready_pulses", 32'(n_tx_ready), 32'(n_tx_ok));
        chk("pre_err_apb_err", 32'(apb_err), 32'd0);

        // Wait states plus slave error on a TX write, then retry
        base    = n_tx_ok;
        tx_wait = 3;
        tx_err  = 1'b1;
        tx_byte = 8'h77;
        tx_exp_q.push_back(8'h77);
        tx_left = 1;
        wait_for("err_retry_done", 1, base + 1, 300);
        chk("err_count", 32'(n_err), 32'd1);
        chk("err_access_len", 32'(err_len), 32'd4);
        chk("err_apb_err", 32'(apb_err), 32'd1);
        chk("err_retry_gap", 32'(ok_cyc - err_cyc), 32'd20);
        repeat (5) tick();
        chk("err_tx_ready_pulses", 32'(n_tx_ready), 32'(n_tx_ok));

        // Reset in the middle of an RX access
        rx_wait  = 5;
        rx_ready = 1'b1;
        base     = n_rx;
        push_uart(3'b000, 8'h99);
        found = 0;
        for (int i = 0; (i < 100) && (found == 0); i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE && (PADDR == ADDR_RXDATA)) found = 1;
        end
        chk("rst_mid_found_rx_access", 32'(found), 32'd1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        chk("rst_mid_psel", 32'(PSEL), 32'd0);
        chk("rst_mid_penable", 32'(PENABLE), 32'd0);
        chk("rst_mid_paddr", 32'(PADDR), 32'd0);
        chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_mid_apb_err", 32'(apb_err), 32'd0);
        chk("rst_mid_no_read", 32'(n_rx - base), 32'd0);
        rx_wait = 0;
        tick();
        PRESET = 1'b0;
        repeat (60) tick();
        chk("post_rst_read", 32'(n_rx - base), 32'd1);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("final_uart_empty", 32'(uart_q.size()), 32'd0);
        chk("final_tx_exp_empty", 32'(tx_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
